// File: rtl/assert_log_pkg.sv
// Shared types and default configuration for the assertion event logger.
package assert_log_pkg;

  localparam int unsigned NumSrcDefault = 4;
  localparam int unsigned DepthDefault  = 8;
  localparam int unsigned TsWDefault    = 16;
  localparam int unsigned MaxSrc        = 16;
  localparam int unsigned MaxTsW        = 32;

  // One logged violation: which sources failed and when, at the widest supported sizes.
  typedef struct packed {
    logic [MaxSrc-1:0] mask;
    logic [MaxTsW-1:0] ts;
  } rec_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/assert_log_if.sv
// Record read-out handshake between the logger (master) and its reader (slave).
interface assert_log_if
  import assert_log_pkg::*;
#(
  parameter int unsigned NUM_SRC = NumSrcDefault,
  parameter int unsigned TS_W    = TsWDefault
) ();

  logic               rec_valid_o;
  logic               rec_ready_i;
  logic [NUM_SRC-1:0] rec_mask_o;
  logic [TS_W-1:0]    rec_ts_o;

  modport master (
    output rec_valid_o,
    output rec_mask_o,
    output rec_ts_o,
    input  rec_ready_i
  );

  modport slave (
    input  rec_valid_o,
    input  rec_mask_o,
    input  rec_ts_o,
    output rec_ready_i
  );

endinterface

// File: rtl/assert_log_fifo.sv
// Record buffer for the event logger: circular storage with pointers and an occupancy count.
module assert_log_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  // Empty reads as zero so the head fields are clean after reset or flush.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/assert_event_logger.sv
// Assertion event logger: captures violation cycles into a record FIFO with counters/stickies.
// Optional timestamping is enabled by defining ASSERT_LOG_TIMESTAMP_EN.
module assert_event_logger
  import assert_log_pkg::*;
#(
  parameter int unsigned NUM_SRC = NumSrcDefault,
  parameter int unsigned DEPTH   = DepthDefault,
  parameter int unsigned TS_W    = TsWDefault
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic [NUM_SRC-1:0] fail_i,
  assert_log_if.master       rec,
  output logic               any_fail_o,
  output logic               overflow_o,
  output logic [15:0]        fail_cnt_o
);

`ifdef ASSERT_LOG_TIMESTAMP_EN
  localparam int unsigned RecW = NUM_SRC + TS_W;
`else
  localparam int unsigned RecW = NUM_SRC;
`endif

  logic            event_w;
  logic            pop_w;
  logic            fifo_empty;
  logic            fifo_full;
  logic [RecW-1:0] wdata;
  logic [RecW-1:0] rdata;

  assign event_w = enable_i & (|fail_i);
  assign pop_w   = rec.rec_valid_o & rec.rec_ready_i;

  assign rec.rec_valid_o = ~fifo_empty;
  assign rec.rec_mask_o  = rdata[NUM_SRC-1:0];

`ifdef ASSERT_LOG_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clock) begin
    if (reset || clear_i) ts_q <= '0;
    else                  ts_q <= ts_q + TS_W'(1);
  end

  assign wdata          = {ts_q, fail_i};
  assign rec.rec_ts_o   = rdata[RecW-1:NUM_SRC];
`else
  assign wdata          = fail_i;
  assign rec.rec_ts_o   = {TS_W{1'b0}};
`endif

  assert_log_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(RecW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear_i (clear_i),
    .push_i  (event_w & ~clear_i),
    .pop_i   (pop_w & ~clear_i),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Dropped events still count as violations; only the record is lost.
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      any_fail_o <= 1'b0;
      overflow_o <= 1'b0;
      fail_cnt_o <= 16'h0000;
    end else if (event_w) begin
      any_fail_o <= 1'b1;
      fail_cnt_o <= sat_inc16(fail_cnt_o);
      if (fifo_full && !pop_w) overflow_o <= 1'b1;
    end
  end

endmodule

// File: doc/assert_event_logger.md
ASSERT_EVENT_LOGGER -- requirements
Module: assert_event_logger

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of monitored assertion sources (1..16).
REQ-002 SHALL have parameter DEPTH, default 8, record buffer entries (power of two, >=2).
REQ-003 SHALL have parameter TS_W, default 16, timestamp width in bits.
REQ-004 SHALL have port clock  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable_i  input  1  capture enable.
REQ-007 SHALL have port clear_i  input  1  synchronous flush of log, counters and stickies.
REQ-008 SHALL have port fail_i  input  NUM_SRC  per-source violation flag, 1 = assertion condition false this cycle.
REQ-009 SHALL have port rec_valid_o  output  1  head record available.
REQ-010 SHALL have port rec_ready_i  input  1  reader accepts head record.
REQ-011 SHALL have port rec_mask_o  output  NUM_SRC  failing-source mask of head record.
REQ-012 SHALL have port rec_ts_o  output  TS_W  timestamp of head record.
REQ-013 SHALL have port any_fail_o  output  1  sticky, set by any captured violation.
REQ-014 SHALL have port overflow_o  output  1  sticky, set when a record was dropped.
REQ-015 SHALL have port fail_cnt_o  output  16  saturating count of violation cycles.

Function
REQ-016 SHALL define an event cycle as enable_i=1 and |fail_i=1; fail_i is ignored when enable_i=0.
REQ-017 SHALL form one record per event cycle: {mask=fail_i, ts=current timestamp}; simultaneous sources share one record.
REQ-018 SHALL keep a free-running TS_W timestamp incrementing every cycle, wrapping max->0.
REQ-019 SHALL make a record captured in cycle N visible at rec_valid_o in cycle N+1 when buffer was empty.
REQ-020 SHALL pop the head record on rec_valid_o && rec_ready_i; rec_mask_o/rec_ts_o SHALL hold stable while rec_valid_o && !rec_ready_i.
REQ-021 SHALL push in FIFO order; full with simultaneous pop SHALL accept the push; full without pop SHALL drop it and set overflow_o.
REQ-022 SHALL drive rec_valid_o=0 when empty; rec_ready_i while empty SHALL have no effect.
REQ-023 SHALL increment fail_cnt_o on every event cycle, including dropped ones, saturating at 16'hFFFF.
REQ-024 SHALL set any_fail_o on the cycle after the first event; stickies clear only via reset or clear_i.
REQ-025 SHALL give clear_i priority: in a clear_i cycle, buffer empties, stickies and fail_cnt_o go to 0, timestamp goes to 0, any event or pop that cycle is discarded.

Reset
REQ-026 SHALL on reset set rec_valid_o=0, rec_mask_o=0, rec_ts_o=0, any_fail_o=0, overflow_o=0, fail_cnt_o=0, timestamp=0, pointers=0.
REQ-027 SHALL abandon an in-progress handshake on reset; the pending head record is lost.

Configuration
REQ-028 SHALL support macro ASSERT_LOG_TIMESTAMP_EN: defined -> timestamp counter and rec_ts_o per REQ-018; undefined -> no counter or ts storage, rec_ts_o tied 0.

Structure
REQ-029 SHALL place record typedef (mask, ts) and default parameter constants in package assert_log_pkg.
REQ-030 SHALL implement buffering in sub-module assert_log_fifo (storage, pointers, full/empty); top holds capture, timestamp, counters, stickies.

Verification
REQ-031 SHALL cover: fail_i=4'b0010 one cycle at ts=5, ready=1 -> next cycle rec_valid_o=1, mask=0010, ts=5, any_fail_o=1, fail_cnt_o=1.
REQ-032 SHALL cover: ready=0, 9 consecutive events, DEPTH=8 -> 8 records held, overflow_o=1, fail_cnt_o=9, drained in order.
REQ-033 SHALL cover: buffer full, event plus pop same cycle -> push accepted, overflow_o stays 0.
REQ-034 SHALL cover: enable_i=0 with fail_i=4'b1111 -> no record, fail_cnt_o=0; clear_i concurrent with event -> all state 0.
REQ-035 SHALL cover: 70000 event cycles -> fail_cnt_o=16'hFFFF; build without ASSERT_LOG_TIMESTAMP_EN -> rec_ts_o=0 always.
